// File: rtl/machine_mode_types_1_13_pkg.sv
// Shared types for the machine-mode trap responder: cause codes, FSM state,
// the exception request bundle and the mtval qualification helper.
package machine_mode_types_1_13_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 5;

   // Synchronous exception cause codes (mcause[31] = 0).
   typedef enum logic [CODE_W-1:0] {
      EX_INSN_MISALIGN  = 5'd0,
      EX_INSN_FAULT     = 5'd1,
      EX_ILLEGAL_INSN   = 5'd2,
      EX_BREAKPOINT     = 5'd3,
      EX_LOAD_MISALIGN  = 5'd4,
      EX_LOAD_FAULT     = 5'd5,
      EX_STORE_MISALIGN = 5'd6,
      EX_STORE_FAULT    = 5'd7,
      EX_ENV_CALL       = 5'd11,
      EX_INSN_PAGE      = 5'd12,
      EX_LOAD_PAGE      = 5'd13,
      EX_STORE_PAGE     = 5'd15
   } ex_code_t;

   // Interrupt cause codes (mcause[31] = 1).
   typedef enum logic [CODE_W-1:0] {
      INT_SOFT  = 5'd3,
      INT_TIMER = 5'd7,
      INT_EXT   = 5'd11
   } int_code_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_CLEAR,
      ST_REDIRECT,
      ST_WFI
   } trap_state_t;

   // Exception request lines as raised by the hazard unit.
   typedef struct packed {
      logic fault_insn;
      logic mal_insn;
      logic illegal_insn;
      logic fault_l;
      logic mal_l;
      logic fault_s;
      logic mal_s;
      logic breakpoint;
      logic env;
      logic fault_insn_page;
      logic fault_load_page;
      logic fault_store_page;
   } exc_req_t;

   // Causes whose mtval carries the faulting address or instruction.
   function automatic logic cause_has_tval(input ex_code_t code);
      case (code)
         EX_INSN_MISALIGN, EX_INSN_FAULT, EX_ILLEGAL_INSN,
         EX_LOAD_MISALIGN, EX_LOAD_FAULT, EX_STORE_MISALIGN, EX_STORE_FAULT,
         EX_INSN_PAGE, EX_LOAD_PAGE, EX_STORE_PAGE: cause_has_tval = 1'b1;
         default:                                   cause_has_tval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/priv_cause_encoder.sv
// Combinational priority encoder: picks the winning exception or enabled
// interrupt and reports its cause code and whether mtval is meaningful.
module priv_cause_encoder
   import machine_mode_types_1_13_pkg::*;
(
   input  exc_req_t          exc,
   input  logic [2:0]        int_pend,     // {MEIP, MTIP, MSIP}
   input  logic [2:0]        mie_en,       // {MEIE, MTIE, MSIE}
   input  logic              mstatus_mie,
   output logic              valid,
   output logic              is_intr,
   output logic [CODE_W-1:0] code,
   output logic              tval_valid
);

   logic [2:0] int_en;
   logic       ex_hit;
   ex_code_t   ex_code;

   assign int_en = int_pend & mie_en & {3{mstatus_mie}};

   // Fixed-priority pick among simultaneously raised exceptions.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      ex_hit  = 1'b1;
      ex_code = EX_BREAKPOINT;
      if      (exc.breakpoint)       ex_code = EX_BREAKPOINT;
      else if (exc.fault_insn_page)  ex_code = EX_INSN_PAGE;
      else if (exc.fault_insn)       ex_code = EX_INSN_FAULT;
      else if (exc.illegal_insn)     ex_code = EX_ILLEGAL_INSN;
      else if (exc.mal_insn)         ex_code = EX_INSN_MISALIGN;
      else if (exc.env)              ex_code = EX_ENV_CALL;
      else if (exc.mal_s)            ex_code = EX_STORE_MISALIGN;
      else if (exc.mal_l)            ex_code = EX_LOAD_MISALIGN;
      else if (exc.fault_store_page) ex_code = EX_STORE_PAGE;
      else if (exc.fault_load_page)  ex_code = EX_LOAD_PAGE;
      else if (exc.fault_s)          ex_code = EX_STORE_FAULT;
      else if (exc.fault_l)          ex_code = EX_LOAD_FAULT;
      else                           ex_hit  = 1'b0;
   end

   // Exceptions outrank interrupts; interrupts rank external, software, timer.
   always_comb begin
      valid      = 1'b0;
      is_intr    = 1'b0;
      code       = '0;
      tval_valid = 1'b0;
      if (ex_hit) begin
         valid      = 1'b1;
         code       = ex_code;
         tval_valid = cause_has_tval(ex_code);
      end else if (int_en[2]) begin
         valid   = 1'b1;
         is_intr = 1'b1;
         code    = INT_EXT;
      end else if (int_en[0]) begin
         valid   = 1'b1;
         is_intr = 1'b1;
         code    = INT_SOFT;
      end else if (int_en[1]) begin
         valid   = 1'b1;
         is_intr = 1'b1;
         code    = INT_TIMER;
      end
   end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap responder: accepts exception/interrupt/mret/wfi requests,
// commits the trap CSRs and redirects the pipeline once it has drained.
module priv_trap_ctrl
   import machine_mode_types_1_13_pkg::*;
#(
   parameter bit VECTORED = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            fault_insn,
   input  logic            mal_insn,
   input  logic            illegal_insn,
   input  logic            fault_l,
   input  logic            mal_l,
   input  logic            fault_s,
   input  logic            mal_s,
   input  logic            breakpoint,
   input  logic            env,
   input  logic            fault_insn_page,
   input  logic            fault_load_page,
   input  logic            fault_store_page,
   input  logic            mret,
   input  logic            wfi,
   input  logic            pipe_clear,
   input  logic [XLEN-1:0] epc,
   input  logic [XLEN-1:0] badaddr,
   input  logic            timer_int,
   input  logic            soft_int,
   input  logic            ext_int,
   input  logic [2:0]      mie_en,
   input  logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] priv_pc,
   output logic            insert_pc,
   output logic            intr,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] mcause,
   output logic [XLEN-1:0] mtval,
   output logic            mstatus_mie,
   output logic            mstatus_mpie,
   output logic            in_wfi
);

   trap_state_t       state_q, state_d;
   logic [XLEN-1:0]   priv_pc_q, priv_pc_d;
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mcause_q, mcause_d;
   logic [XLEN-1:0]   mtval_q, mtval_d;
   logic              mie_q, mie_d;
   logic              mpie_q, mpie_d;
   logic              intr_q, intr_d;

   exc_req_t          exc_req;
   logic [2:0]        int_pend;
   logic              enc_valid, enc_is_intr, enc_tval_valid;
   logic [CODE_W-1:0] enc_code;

   logic              in_idle, take_exc, take_int, take_trap, take_mret, take_wfi;
   logic              wfi_wake;
   logic [XLEN-1:0]   trap_base, trap_target;

   assign exc_req = '{fault_insn:       fault_insn,
                      mal_insn:         mal_insn,
                      illegal_insn:     illegal_insn,
                      fault_l:          fault_l,
                      mal_l:            mal_l,
                      fault_s:          fault_s,
                      mal_s:            mal_s,
                      breakpoint:       breakpoint,
                      env:              env,
                      fault_insn_page:  fault_insn_page,
                      fault_load_page:  fault_load_page,
                      fault_store_page: fault_store_page};

   assign int_pend = {ext_int, timer_int, soft_int};

   priv_cause_encoder u_cause_enc (
      .exc         (exc_req),
      .int_pend    (int_pend),
      .mie_en      (mie_en),
      .mstatus_mie (mie_q),
      .valid       (enc_valid),
      .is_intr     (enc_is_intr),
      .code        (enc_code),
      .tval_valid  (enc_tval_valid)
   );

   // Request arbitration in IDLE: exception > mret > wfi > interrupt.
   assign in_idle   = (state_q == ST_IDLE);
   assign take_exc  = in_idle && enc_valid && !enc_is_intr;
   assign take_mret = in_idle && !take_exc && mret;
   assign take_wfi  = in_idle && !take_exc && !mret && wfi;
   assign take_int  = in_idle && enc_valid && enc_is_intr && !mret && !wfi;
   assign take_trap = take_exc || take_int;

   // WFI wakes on any locally enabled pending line, ignoring the global enable.
   assign wfi_wake = |(int_pend & mie_en);

   // Modes 2 and 3 of mtvec fall back to direct mode.
   assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
   assign trap_target = (VECTORED && enc_is_intr && (mtvec[1:0] == 2'b01))
                        ? trap_base + {{(XLEN-CODE_W-2){1'b0}}, enc_code, 2'b00}
                        : trap_base;

   // FSM state register.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take_trap || take_mret) state_d = ST_WAIT_CLEAR;
            else if (take_wfi)          state_d = ST_WFI;
         end
         ST_WAIT_CLEAR: if (pipe_clear) state_d = ST_REDIRECT;
         ST_REDIRECT:                   state_d = ST_IDLE;
         ST_WFI:        if (wfi_wake)   state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      insert_pc = 1'b0;
      in_wfi    = 1'b0;
      case (state_q)
         ST_REDIRECT: insert_pc = 1'b1;
         ST_WFI:      in_wfi    = 1'b1;
         default:     ;
      endcase
   end

   // CSR and redirect-target updates, committed only on an accept edge.
   always_comb begin
      priv_pc_d = priv_pc_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      mtval_d   = mtval_q;
      mie_d     = mie_q;
      mpie_d    = mpie_q;
      intr_d    = intr_q;
      if (take_trap) begin
         priv_pc_d = trap_target;
         mepc_d    = epc & ~{{(XLEN-1){1'b0}}, 1'b1};
         mcause_d  = {enc_is_intr, {(XLEN-CODE_W-1){1'b0}}, enc_code};
         mtval_d   = enc_tval_valid ? badaddr : '0;
         mpie_d    = mie_q;
         mie_d     = 1'b0;
         intr_d    = enc_is_intr;
      end else if (take_mret) begin
         priv_pc_d = mepc_q;
         mie_d     = mpie_q;
         mpie_d    = 1'b1;
         intr_d    = 1'b0;
      end else if (state_q == ST_REDIRECT) begin
         intr_d    = 1'b0;
      end
   end

   // CSR registers.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: all CSR flops are reset so a trap aborted mid-flight leaves no partial commit.
      if (RST) begin
         priv_pc_q <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
         mtval_q   <= '0;
         mie_q     <= 1'b0;
         mpie_q    <= 1'b0;
         intr_q    <= 1'b0;
      end else begin
         priv_pc_q <= priv_pc_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
         mtval_q   <= mtval_d;
         mie_q     <= mie_d;
         mpie_q    <= mpie_d;
         intr_q    <= intr_d;
      end
   end

   assign priv_pc      = priv_pc_q;
   assign mepc         = mepc_q;
   assign mcause       = mcause_q;
   assign mtval        = mtval_q;
   assign mstatus_mie  = mie_q;
   assign mstatus_mpie = mpie_q;
   assign intr         = intr_q;

endmodule

// File: doc/priv_trap_ctrl.md
# priv_trap_ctrl

Machine-mode trap responder inside the privilege block: consumes the exception, interrupt, `mret` and `wfi` requests that the pipeline's hazard unit raises on `prv_pipeline_if`, prioritises them and commits `mepc`/`mcause`/`mtval`/`mstatus.MIE,MPIE`. It then drives `insert_pc`, `priv_pc` and `intr` back to the pipeline once the pipeline reports `pipe_clear`. It is the privilege-block end of the hazard-side trap handshake and sits between the CSR file and the `prv_pipeline_if` `priv_block` modport.

## Interface
- `VECTORED`, default 1: honour `mtvec.MODE`=1 vectoring for interrupts; 0 forces direct mode.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env, fault_insn_page, fault_load_page, fault_store_page` in 1 each: exception requests from hazard unit.
- `mret, wfi` in 1: return / wait-for-interrupt requests.
- `pipe_clear` in 1: pipeline drained, safe to redirect.
- `epc, badaddr` in 32: faulting PC, faulting address/instruction.
- `timer_int, soft_int, ext_int` in 1: level interrupt pending lines (MTIP, MSIP, MEIP).
- `mie_en` in 3: `mie` bits {MEIE, MTIE, MSIE}.
- `mtvec` in 32: trap vector CSR value.
- `priv_pc` out 32: redirect target.
- `insert_pc` out 1: one-cycle redirect strobe.
- `intr` out 1: current trap is an interrupt.
- `mepc, mcause, mtval` out 32 each: trap CSR contents.
- `mstatus_mie, mstatus_mpie` out 1 each: status bits.
- `in_wfi` out 1: core stalled in WFI.

## Operation
- States: IDLE, WAIT_CLEAR, REDIRECT, WFI.
- IDLE, priority order (highest first): exceptions > `mret` > `wfi` > interrupts.
- Exception priority and cause: breakpoint 3, fault_insn_page 12, fault_insn 1, illegal_insn 2, mal_insn 0, env 11, mal_s 6, mal_l 4, fault_store_page 15, fault_load_page 13, fault_s 7, fault_l 5.
- Interrupt priority (taken only if `mstatus_mie` and the matching `mie_en` bit are set): ext 11, soft 3, timer 7. `mcause[31]`=1 for interrupts.
- Trap accept edge:
  - `mepc`<=`epc` with bit 0 cleared.
  - `mcause`<=code.
  - `mtval`<=`badaddr` for causes 0,1,2,4,5,6,7,12,13,15; otherwise 0.
  - `mstatus_mpie`<=`mstatus_mie`; `mstatus_mie`<=0.
  - Go to WAIT_CLEAR.
- `mret` accept edge: `mstatus_mie`<=`mstatus_mpie`, `mstatus_mpie`<=1; go to WAIT_CLEAR with target `mepc`.
- `wfi` accept: go to WFI, `in_wfi`=1. Exit to IDLE when any (`{ext,timer,soft}` & `mie_en`) is nonzero, regardless of `mstatus_mie`. The interrupt, if globally enabled, is taken from IDLE on the next cycle.
- WAIT_CLEAR: hold until `pipe_clear`=1, then go to REDIRECT. New requests are ignored.
- REDIRECT: `insert_pc`=1 for exactly one cycle, then IDLE.
- Target (registered at accept):
  - Trap: `{mtvec[31:2],2'b00}`, plus `4*code` when interrupt && `mtvec[1:0]`==1 && `VECTORED`.
  - `mret`: `mepc`.
- `mtvec[1:0]`>=2: treated as direct.
- `intr` is high from accept through REDIRECT for interrupts, else 0.

## Timing
- Reset values:
  - State IDLE.
  - `priv_pc`, `mepc`, `mcause`, `mtval` = 0.
  - `insert_pc`, `intr`, `in_wfi`, `mstatus_mie`, `mstatus_mpie` = 0.
- Latency:
  - Request at cycle N → CSRs updated at N+1.
  - `pipe_clear` sampled high at cycle M≥N+1 → `insert_pc`=1 during M+1.
  - Minimum request-to-redirect latency: 2 cycles.
- Simultaneous events:
  - Exception and interrupt in the same cycle: exception wins; the interrupt stays pending (level input) and is re-evaluated in IDLE.
  - `pipe_clear` high during IDLE has no effect.
  - `pipe_clear` already high on the accept edge: it is not sampled; it is sampled from the next cycle on.
- `RST` asserted mid-operation: immediately returns to the reset values, including mid-WAIT_CLEAR and WFI. No partial commit survives.
- `priv_pc` stays stable from accept until the next accept.

## Structure
- Cause codes (`ex_code_t`, `int_code_t`) and the state enum belong in `machine_mode_types_1_13_pkg`.
- Sub-module `priv_cause_encoder`: combinational priority encoder. Takes the request vectors, enables and `mstatus_mie`; outputs `valid`, `is_intr`, 5-bit code and a `tval_valid` flag.
- The top level holds the FSM, the CSR registers and target computation.

## Test plan
- Reset: `illegal_insn`=1 with `epc`=0x100 and `badaddr`=0xDEAD0013; after 1 cycle `mcause`=2, `mepc`=0x100, `mtval`=0xDEAD0013. With `pipe_clear` at cycle 3, `insert_pc`=1 at cycle 4 with `priv_pc`=`mtvec`=0x200.
- `mstatus_mie`=1, `mie_en`=3'b010, `mtvec`=0x301, `timer_int`=1: `mcause`=0x80000007, `intr`=1, `priv_pc`=0x31C, `mstatus_mie`=0, `mstatus_mpie`=1.
- `mal_l` and `ext_int` both enabled in the same cycle: `mcause`=4, `intr`=0. After `mret` redirect, `mcause`=0x8000000B.
- `mret` with `mepc`=0x400, `mstatus_mpie`=1: `priv_pc`=0x400, `mstatus_mie`=1, `mstatus_mpie`=1.
- `wfi` with `mstatus_mie`=0, then `soft_int`=1 with `mie_en[0]`=1: `in_wfi` drops next cycle and no trap is taken.
- `RST` pulsed during WAIT_CLEAR: `insert_pc` never asserts and all outputs return to 0.
